// File: rtl/hssdrc_sys_req_buffer.sv
// rtl/hssdrc_sys_req_buffer.sv - command and write-data request buffer ahead of hssdrc_top
// Define HSSDRC_REQ_BUF_STAT_EN to add the cmd_level/data_level/err_underflow status outputs.
module hssdrc_sys_req_buffer #(
   parameter int pCmdDepth  = 4,
   parameter int pDataDepth = 16,
   parameter int pRowaBits  = 12,
   parameter int pColaBits  = 8,
   parameter int pBaBits    = 2,
   parameter int pBurstBits = 2,
   parameter int pChidBits  = 2,
   parameter int pDataBits  = 32,
   parameter int pDatamBits = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclr,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [pRowaBits-1:0]  req_rowa,
   input  logic [pColaBits-1:0]  req_cola,
   input  logic [pBaBits-1:0]    req_ba,
   input  logic [pBurstBits-1:0] req_burst,
   input  logic [pChidBits-1:0]  req_chid,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [pDataBits-1:0]  wr_data,
   input  logic [pDatamBits-1:0] wr_datam,
   output logic                  sys_write,
   output logic                  sys_read,
   output logic                  sys_refr,
   output logic [pRowaBits-1:0]  sys_rowa,
   output logic [pColaBits-1:0]  sys_cola,
   output logic [pBaBits-1:0]    sys_ba,
   output logic [pBurstBits-1:0] sys_burst,
   output logic [pChidBits-1:0]  sys_chid_i,
   input  logic                  sys_ready,
   output logic [pDataBits-1:0]  sys_wdata,
   output logic [pDatamBits-1:0] sys_wdatam,
   input  logic                  sys_use_wdata
`ifdef HSSDRC_REQ_BUF_STAT_EN
   ,
   output logic [$clog2(pCmdDepth):0]  cmd_level,
   output logic [$clog2(pDataDepth):0] data_level,
   output logic                        err_underflow
`endif
);
   localparam int CW = $clog2(pCmdDepth);
   localparam int DW = $clog2(pDataDepth);
   localparam int FW = pRowaBits + pColaBits + pBaBits + pBurstBits + pChidBits;
   localparam int EW = 2 + FW;
   localparam int MW = pDataBits + pDatamBits;

   logic [EW-1:0] r_cmd_mem [pCmdDepth];
   logic [CW:0]   r_cmd_wp;
   logic [CW:0]   r_cmd_rp;
   logic [MW-1:0] r_dat_mem [pDataDepth];
   logic [DW:0]   r_dat_wp;
   logic [DW:0]   r_dat_rp;
   logic [DW:0]   r_credit;

   logic          w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;
   logic          w_dat_empty, w_dat_full, w_dat_push, w_dat_pop;
   logic [EW-1:0] w_head;
   logic [1:0]    w_head_op;
   logic [DW:0]   w_beats;
   logic          w_credit_ok;
   logic          w_wr_issue;

   assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
   assign w_cmd_full  = (r_cmd_wp[CW] != r_cmd_rp[CW]) && (r_cmd_wp[CW-1:0] == r_cmd_rp[CW-1:0]);
   assign w_dat_empty = (r_dat_wp == r_dat_rp);
   assign w_dat_full  = (r_dat_wp[DW] != r_dat_rp[DW]) && (r_dat_wp[DW-1:0] == r_dat_rp[DW-1:0]);

   assign req_ready  = !w_cmd_full;
   assign wr_ready   = !w_dat_full;
   assign w_cmd_push = req_valid && !w_cmd_full;
   assign w_dat_push = wr_valid && !w_dat_full;
   assign w_dat_pop  = sys_use_wdata && !w_dat_empty;

   // Empty FIFOs present all-zero heads so outputs are clean after reset.
   assign w_head = w_cmd_empty ? '0 : r_cmd_mem[r_cmd_rp[CW-1:0]];
   assign {w_head_op, sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i} = w_head;
   assign {sys_wdata, sys_wdatam} = w_dat_empty ? '0 : r_dat_mem[r_dat_rp[DW-1:0]];

   assign w_beats     = (DW+1)'(sys_burst) + (DW+1)'(1);
   assign w_credit_ok = (r_credit >= w_beats);
   assign sys_write   = !w_cmd_empty && (w_head_op == 2'b01) && w_credit_ok;
   assign sys_refr    = !w_cmd_empty && (w_head_op == 2'b10);
   // Reserved op 11 behaves as a read.
   assign sys_read    = !w_cmd_empty && (w_head_op[0] == w_head_op[1]);
   assign w_cmd_pop   = (sys_write || sys_read || sys_refr) && sys_ready;
   assign w_wr_issue  = sys_write && sys_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd_wp <= '0;
         r_cmd_rp <= '0;
         r_dat_wp <= '0;
         r_dat_rp <= '0;
         r_credit <= '0;
      end else if (sclr) begin
         r_cmd_wp <= '0;
         r_cmd_rp <= '0;
         r_dat_wp <= '0;
         r_dat_rp <= '0;
         r_credit <= '0;
      end else begin
         if (w_cmd_push) r_cmd_wp <= r_cmd_wp + (CW+1)'(1);
         if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + (CW+1)'(1);
         if (w_dat_push) r_dat_wp <= r_dat_wp + (DW+1)'(1);
         if (w_dat_pop)  r_dat_rp <= r_dat_rp + (DW+1)'(1);
         // A write reserves its whole burst at issue so later writes cannot borrow its beats.
         r_credit <= r_credit + (DW+1)'(w_dat_push) - (w_wr_issue ? w_beats : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_cmd_push) r_cmd_mem[r_cmd_wp[CW-1:0]] <= {req_op, req_rowa, req_cola, req_ba, req_burst, req_chid};
      if (w_dat_push) r_dat_mem[r_dat_wp[DW-1:0]] <= {wr_data, wr_datam};
   end

`ifdef HSSDRC_REQ_BUF_STAT_EN
   logic r_err_underflow;

   assign cmd_level     = r_cmd_wp - r_cmd_rp;
   assign data_level    = r_dat_wp - r_dat_rp;
   assign err_underflow = r_err_underflow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             r_err_underflow <= 1'b0;
      else if (sclr)                          r_err_underflow <= 1'b0;
      else if (sys_use_wdata && w_dat_empty)  r_err_underflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_hssdrc_sys_req_buffer.sv
// tb/tb_hssdrc_sys_req_buffer.sv - directed and randomized checks of hssdrc_sys_req_buffer
module tb_hssdrc_sys_req_buffer;
   localparam int CD = 4, DD = 16, RB = 12, CB = 8, BB = 2, UB = 2, HB = 2, DB = 32, MB = 4;
   localparam int FW = RB + CB + BB + UB + HB;

   logic clk = 1'b0;
   logic reset, sclr;
   logic req_valid, req_ready;
   logic [1:0] req_op;
   logic [RB-1:0] req_rowa;
   logic [CB-1:0] req_cola;
   logic [BB-1:0] req_ba;
   logic [UB-1:0] req_burst;
   logic [HB-1:0] req_chid;
   logic wr_valid, wr_ready;
   logic [DB-1:0] wr_data;
   logic [MB-1:0] wr_datam;
   logic sys_write, sys_read, sys_refr;
   logic [RB-1:0] sys_rowa;
   logic [CB-1:0] sys_cola;
   logic [BB-1:0] sys_ba;
   logic [UB-1:0] sys_burst;
   logic [HB-1:0] sys_chid_i;
   logic sys_ready;
   logic [DB-1:0] sys_wdata;
   logic [MB-1:0] sys_wdatam;
   logic sys_use_wdata;
`ifdef HSSDRC_REQ_BUF_STAT_EN
   logic [$clog2(CD):0] cmd_level;
   logic [$clog2(DD):0] data_level;
   logic err_underflow;
`endif

   hssdrc_sys_req_buffer dut (
      .clk(clk), .reset(reset), .sclr(sclr),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rowa(req_rowa), .req_cola(req_cola), .req_ba(req_ba),
      .req_burst(req_burst), .req_chid(req_chid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_datam(wr_datam),
      .sys_write(sys_write), .sys_read(sys_read), .sys_refr(sys_refr),
      .sys_rowa(sys_rowa), .sys_cola(sys_cola), .sys_ba(sys_ba),
      .sys_burst(sys_burst), .sys_chid_i(sys_chid_i), .sys_ready(sys_ready),
      .sys_wdata(sys_wdata), .sys_wdatam(sys_wdatam), .sys_use_wdata(sys_use_wdata)
`ifdef HSSDRC_REQ_BUF_STAT_EN
      , .cmd_level(cmd_level), .data_level(data_level), .err_underflow(err_underflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    op;
      logic [RB-1:0] rowa;
      logic [CB-1:0] cola;
      logic [BB-1:0] ba;
      logic [UB-1:0] burst;
      logic [HB-1:0] chid;
   } cmd_t;

   // Reference model: queues of pending commands and buffered words, plus unreserved word count.
   cmd_t             cq[$];
   logic [DB+MB-1:0] dq[$];
   int               credit = 0;
   int               checks = 0;
   int               failures = 0;

   function automatic logic [2:0] exp_strobe();
      if (cq.size() == 0) return 3'b000;
      case (cq[0].op)
         2'b01:   return {(credit >= int'(cq[0].burst) + 1), 2'b00};
         2'b10:   return 3'b001;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [FW-1:0] exp_fields();
      cmd_t c;
      if (cq.size() == 0) return '0;
      c = cq[0];
      return c[FW-1:0];
   endfunction

   function automatic logic [DB+MB-1:0] exp_wdata();
      if (dq.size() == 0) return '0;
      return dq[0];
   endfunction

   task automatic set_idle();
      req_valid = 0; req_op = 0; req_rowa = 0; req_cola = 0; req_ba = 0; req_burst = 0; req_chid = 0;
      wr_valid = 0; wr_data = 0; wr_datam = 0; sys_ready = 0; sys_use_wdata = 0; sclr = 0;
   endtask

   // Advance one clock: update the model from the inputs applied this cycle, then return at the next negedge.
   task automatic tick();
      logic [2:0] st;
      bit rc, rd;
      cmd_t c;
      #1;
      rc = cq.size() < CD;
      rd = dq.size() < DD;
      st = exp_strobe();
      if (!reset || sclr) begin
         cq.delete(); dq.delete(); credit = 0;
      end else begin
         if (st != 3'b000 && sys_ready) begin
            if (st[2]) credit -= int'(cq[0].burst) + 1;
            void'(cq.pop_front());
         end
         if (sys_use_wdata && dq.size() > 0) void'(dq.pop_front());
         if (req_valid && rc) begin
            c = {req_op, req_rowa, req_cola, req_ba, req_burst, req_chid};
            cq.push_back(c);
         end
         if (wr_valid && rd) begin
            dq.push_back({wr_data, wr_datam});
            credit++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [RB-1:0] rowa, input logic [UB-1:0] burst);
      req_valid = 1; req_op = op; req_rowa = rowa; req_cola = CB'($urandom);
      req_ba = BB'($urandom); req_burst = burst; req_chid = HB'($urandom);
      tick();
      req_valid = 0;
   endtask

   task automatic push_word(input logic [DB+MB-1:0] w);
      wr_valid = 1; {wr_data, wr_datam} = w;
      tick();
      wr_valid = 0;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 0;
      tick(); tick();
      reset = 1;
      tick();
      checks++;
      if ({sys_write, sys_read, sys_refr} !== 3'b000) begin
         failures++; $display("FAIL reset_strobes got=%b exp=000", {sys_write, sys_read, sys_refr});
      end
      checks++;
      if ({req_ready, wr_ready} !== 2'b11) begin
         failures++; $display("FAIL reset_ready got=%b exp=11", {req_ready, wr_ready});
      end
      checks++;
      if ({sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i} !== '0) begin
         failures++; $display("FAIL reset_fields got=%h exp=0", {sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i});
      end
      checks++;
      if ({sys_wdata, sys_wdatam} !== '0) begin
         failures++; $display("FAIL reset_wdata got=%h exp=0", {sys_wdata, sys_wdatam});
      end
   endtask

   task automatic test_write_credit();
      logic [DB+MB-1:0] w[4];
      logic [RB-1:0] row;
      set_idle();
      row = RB'($urandom);
      push_cmd(2'b01, row, 2'd3);
      for (int i = 0; i < 4; i++) w[i] = {32'($urandom), 4'($urandom)};
      for (int i = 0; i < 3; i++) push_word(w[i]);
      checks++;
      if (sys_write !== 1'b0) begin
         failures++; $display("FAIL wr_3of4_words sys_write got=%b exp=0", sys_write);
      end
      sys_ready = 1;
      push_word(w[3]);
      checks++;
      if ({sys_write, sys_rowa} !== {1'b1, row}) begin
         failures++; $display("FAIL wr_4of4_words got=%b/%h exp=1/%h", sys_write, sys_rowa, row);
      end
      tick();
      sys_ready = 0;
      checks++;
      if (sys_write !== 1'b0) begin
         failures++; $display("FAIL wr_after_issue sys_write got=%b exp=0", sys_write);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({sys_wdata, sys_wdatam} !== w[i]) begin
            failures++; $display("FAIL wr_beat%0d got=%h exp=%h", i, {sys_wdata, sys_wdatam}, w[i]);
         end
         sys_use_wdata = 1;
         tick();
         sys_use_wdata = 0;
      end
      // A fresh single-beat write must wait: no credit remains from the first burst.
      push_cmd(2'b01, row, 2'd0);
      checks++;
      if (sys_write !== 1'b0) begin
         failures++; $display("FAIL wr_credit_zero sys_write got=%b exp=0", sys_write);
      end
      sys_ready = 1;
      push_word(w[0]);
      tick();
      sys_ready = 0;
      sys_use_wdata = 1;
      tick();
      sys_use_wdata = 0;
   endtask

   task automatic test_stall_order();
      set_idle();
      push_cmd(2'b01, 12'h005, 2'd1);
      push_cmd(2'b00, 12'h006, 2'd0);
      sys_ready = 1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({sys_write, sys_read} !== 2'b00) begin
            failures++; $display("FAIL stall_inorder cyc%0d got=%b exp=00", i, {sys_write, sys_read});
         end
         tick();
      end
      push_word({32'hA5A5_0001, 4'h3});
      push_word({32'hA5A5_0002, 4'hC});
      checks++;
      if ({sys_write, sys_read, sys_rowa} !== {2'b10, 12'h005}) begin
         failures++; $display("FAIL stall_write_issue got=%b/%h exp=10/005", {sys_write, sys_read}, sys_rowa);
      end
      tick();
      checks++;
      if ({sys_write, sys_read, sys_rowa} !== {2'b01, 12'h006}) begin
         failures++; $display("FAIL stall_read_follow got=%b/%h exp=01/006", {sys_write, sys_read}, sys_rowa);
      end
      tick();
      sys_ready = 0;
      sys_use_wdata = 1;
      tick(); tick();
      sys_use_wdata = 0;
   endtask

   task automatic test_full();
      set_idle();
      for (int i = 0; i < 4; i++) push_cmd(2'b00, RB'(100 + i), 2'd0);
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL full_req_ready got=%b exp=0", req_ready);
      end
      push_cmd(2'b00, 12'd999, 2'd0);
      sys_ready = 1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({sys_read, sys_rowa} !== {1'b1, RB'(100 + i)}) begin
            failures++; $display("FAIL full_issue%0d got=%b/%0d exp=1/%0d", i, sys_read, sys_rowa, 100 + i);
         end
         tick();
         if (i == 0) begin
            checks++;
            if (req_ready !== 1'b1) begin
               failures++; $display("FAIL full_ready_after_pop got=%b exp=1", req_ready);
            end
         end
      end
      checks++;
      if ({sys_write, sys_read, sys_refr} !== 3'b000) begin
         failures++; $display("FAIL full_fifth_dropped got=%b exp=000", {sys_write, sys_read, sys_refr});
      end
      sys_ready = 0;
      for (int i = 0; i < 17; i++) push_word({32'($urandom), 4'($urandom)});
      checks++;
      if (wr_ready !== 1'b0) begin
         failures++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready);
      end
      sclr = 1;
      tick();
      sclr = 0;
      checks++;
      if ({wr_ready, sys_wdata, sys_wdatam} !== {1'b1, 36'h0}) begin
         failures++; $display("FAIL sclr_clear got=%b/%h exp=1/0", wr_ready, {sys_wdata, sys_wdatam});
      end
   endtask

   task automatic test_refr_hold();
      logic [FW-1:0] f;
      set_idle();
      push_cmd(2'b10, RB'($urandom), UB'($urandom));
      f = {sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i};
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({sys_refr, sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i} !== {1'b1, exp_fields()} ||
             {sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i} !== f) begin
            failures++; $display("FAIL refr_hold cyc%0d got=%b/%h exp=1/%h", i, sys_refr,
                                 {sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i}, exp_fields());
         end
         tick();
      end
      sys_ready = 1;
      tick();
      sys_ready = 0;
      checks++;
      if (sys_refr !== 1'b0) begin
         failures++; $display("FAIL refr_popped got=%b exp=0", sys_refr);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [DB+MB-1:0] w;
      set_idle();
      push_cmd(2'b01, 12'h0AB, 2'd3);
      push_cmd(2'b00, 12'h0CD, 2'd0);
      for (int i = 0; i < 4; i++) push_word({32'($urandom), 4'($urandom)});
      sys_ready = 1;
      tick();
      sys_ready = 0;
      sys_use_wdata = 1;
      tick(); tick();
      sys_use_wdata = 0;
      reset = 0;
      #1;
      checks++;
      if ({sys_write, sys_read, sys_refr, req_ready, wr_ready} !== 5'b00011) begin
         failures++; $display("FAIL midburst_reset got=%b exp=00011", {sys_write, sys_read, sys_refr, req_ready, wr_ready});
      end
      checks++;
      if ({sys_wdata, sys_wdatam} !== '0) begin
         failures++; $display("FAIL midburst_wdata got=%h exp=0", {sys_wdata, sys_wdatam});
      end
`ifdef HSSDRC_REQ_BUF_STAT_EN
      checks++;
      if ({cmd_level, data_level, err_underflow} !== '0) begin
         failures++; $display("FAIL midburst_levels got=%0d/%0d/%b exp=0/0/0", cmd_level, data_level, err_underflow);
      end
`endif
      tick();
      reset = 1;
      sys_use_wdata = 1;
      tick();
      sys_use_wdata = 0;
      tick(); tick();
`ifdef HSSDRC_REQ_BUF_STAT_EN
      checks++;
      if (err_underflow !== 1'b1) begin
         failures++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow);
      end
`endif
      w = {32'h1234_5678, 4'h9};
      push_word(w);
      checks++;
      if ({sys_wdata, sys_wdatam} !== w) begin
         failures++; $display("FAIL underflow_ignored got=%h exp=%h", {sys_wdata, sys_wdatam}, w);
      end
      sclr = 1;
      tick();
      sclr = 0;
`ifdef HSSDRC_REQ_BUF_STAT_EN
      checks++;
      if (err_underflow !== 1'b0) begin
         failures++; $display("FAIL underflow_sclr got=%b exp=0", err_underflow);
      end
`endif
   endtask

   task automatic test_random();
      set_idle();
      for (int n = 0; n < 4000; n++) begin
         checks++;
         if ({req_ready, wr_ready} !== {cq.size() < CD, dq.size() < DD}) begin
            failures++;
            if (failures < 30) $display("FAIL rnd_ready cyc%0d got=%b exp=%b", n, {req_ready, wr_ready}, {cq.size() < CD, dq.size() < DD});
         end
         checks++;
         if ({sys_write, sys_read, sys_refr} !== exp_strobe()) begin
            failures++;
            if (failures < 30) $display("FAIL rnd_strobe cyc%0d got=%b exp=%b", n, {sys_write, sys_read, sys_refr}, exp_strobe());
         end
         checks++;
         if ({sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i} !== exp_fields()) begin
            failures++;
            if (failures < 30) $display("FAIL rnd_fields cyc%0d got=%h exp=%h", n, {sys_rowa, sys_cola, sys_ba, sys_burst, sys_chid_i}, exp_fields());
         end
         checks++;
         if ({sys_wdata, sys_wdatam} !== exp_wdata()) begin
            failures++;
            if (failures < 30) $display("FAIL rnd_wdata cyc%0d got=%h exp=%h", n, {sys_wdata, sys_wdatam}, exp_wdata());
         end
`ifdef HSSDRC_REQ_BUF_STAT_EN
         checks++;
         if (int'(cmd_level) != cq.size() || int'(data_level) != dq.size()) begin
            failures++;
            if (failures < 30) $display("FAIL rnd_levels cyc%0d got=%0d/%0d exp=%0d/%0d", n, cmd_level, data_level, cq.size(), dq.size());
         end
`endif
         req_valid = ($urandom_range(0, 1) == 1);
         req_op = 2'($urandom); req_rowa = RB'($urandom); req_cola = CB'($urandom);
         req_ba = BB'($urandom); req_burst = UB'($urandom); req_chid = HB'($urandom);
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_data = $urandom; wr_datam = MB'($urandom);
         sys_ready = ($urandom_range(0, 9) < 6);
         sys_use_wdata = (dq.size() > credit) && ($urandom_range(0, 9) < 7);
         sclr = ($urandom_range(0, 499) == 0);
         tick();
      end
      set_idle();
   endtask

   initial begin
      reset = 0;
      test_reset();
      test_write_credit();
      test_stall_order();
      test_full();
      test_refr_hold();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hssdrc_sys_req_buffer.md
Name: hssdrc_sys_req_buffer

Overview:
- Request buffer directly upstream of hssdrc_top; drives its sys_* command and write-data inputs.
- Decouples a client (valid/ready) from the controller's sys_ready / sys_use_wdata timing with a command FIFO and a write-data FIFO.
- A write command is presented to the controller only when its full burst of data is already buffered, so sys_use_wdata never finds the data FIFO empty.

Parameters:
- pCmdDepth, 4: command FIFO entries (power of 2, ≥2).
- pDataDepth, 16: write-data FIFO words (power of 2, ≥ max burst beats = 2**pBurstBits).
- pRowaBits, 12: row address width.
- pColaBits, 8: column address width.
- pBaBits, 2: bank width.
- pBurstBits, 2: burst field width; beats = burst+1.
- pChidBits, 2: channel id width.
- pDataBits, 32: data width.
- pDatamBits, 4: byte-mask width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- sclr  in  1  synchronous clear, active-high; same effect as reset.
- req_valid  in  1  client command valid.
- req_ready  out  1  command FIFO not full.
- req_op  in  2  00 read, 01 write, 10 refresh, 11 reserved (treated as read).
- req_rowa / req_cola / req_ba / req_burst / req_chid  in  field widths  command fields.
- wr_valid  in  1  write-data word valid.
- wr_ready  out  1  data FIFO not full.
- wr_data  in  pDataBits  write word.
- wr_datam  in  pDatamBits  byte mask.
- sys_write / sys_read / sys_refr  out  1  head command strobe to hssdrc_top.
- sys_rowa / sys_cola / sys_ba / sys_burst / sys_chid_i  out  field widths  head command fields.
- sys_ready  in  1  controller accepts presented command this edge.
- sys_wdata  out  pDataBits  data FIFO head.
- sys_wdatam  out  pDatamBits  mask FIFO head.
- sys_use_wdata  in  1  controller consumes data FIFO head this edge.

Behaviour:
- Reset/sclr: both FIFOs empty, credit=0, all pointers 0.
  - Resulting outputs: sys_write/read/refr=0, sys_* fields=0, req_ready=1, wr_ready=1, sys_wdata/sys_wdatam=0.
  - Reset mid-burst discards all buffered data.
- Command push: req_valid & req_ready; 0-cycle bypass not allowed. The entry becomes head-visible the cycle after the push.
- Data push: wr_valid & wr_ready → credit+1.
- credit: counter 0..pDataDepth of buffered words not yet reserved by an issued write.
- Head presentation (combinational from registered head entry):
  - Read/refresh head: strobe asserted whenever the command FIFO is non-empty.
  - Write head: sys_write asserted only if credit ≥ burst+1.
- Issue: strobe & sys_ready → pop command. For a write, credit -= burst+1 in the same edge.
- Simultaneous data push and write issue: credit += 1 - (burst+1).
- Fields are held stable while a strobe is asserted and sys_ready=0.
- sys_use_wdata: pops one data word. Words leave in push order; beats follow the issue order of writes.
- Full/empty:
  - Push to a full FIFO is ignored (ready=0).
  - Simultaneous push and pop on a full FIFO: pop occurs, push is blocked because ready was 0.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged.
- Pointers wrap modulo depth; full/empty use an extra wrap bit.
- sys_use_wdata with the data FIFO empty is a protocol violation: the pop is ignored and the pointer does not move.

Optional Feature:
- Macro HSSDRC_REQ_BUF_STAT_EN. When defined, adds three outputs:
  - cmd_level [$clog2(pCmdDepth):0]: command FIFO occupancy.
  - data_level [$clog2(pDataDepth):0]: data FIFO occupancy.
  - err_underflow (1): sticky; set on sys_use_wdata with the data FIFO empty, cleared only by reset or sclr.
- When not defined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Write, burst=3, all 4 words pushed first, sys_ready=1 → sys_write high one cycle after the 4th word push. Four sys_use_wdata pulses deliver words in push order, then credit=0.
- Write burst=3 pushed with only 3 data words → sys_write stays 0. Push the 4th word → sys_write=1 the next cycle.
- Read queued behind a stalled write (credit insufficient) → read is not presented (in-order). Supply data → write issues, then read issues on the following accepted cycle.
- Push 4 commands with sys_ready=0 → req_ready=0 after the 4th. A 5th push is ignored. Raise sys_ready → commands issue in order, 4 total, req_ready=1 after the first pop.
- Hold sys_ready=0 for 10 cycles with a refresh at head → sys_refr and fields stable all 10 cycles.
- Assert reset mid-burst (2 of 4 beats consumed) → all strobes 0, req_ready=wr_ready=1. With STAT_EN: cmd_level=data_level=0. Force sys_use_wdata on empty → err_underflow=1 and sticky.
